// File: rtl/ingreso_numero_pkg.sv
// Shared types and key codes for the digit-entry accumulator.
// With INGRESO_BIN_EN defined the state set gains the BCD-to-binary conversion step.
package ingreso_pkg;

`ifdef INGRESO_BIN_EN
  typedef enum logic [2:0] {VACIO, CARGANDO, LLENO, ENTREGA, CONVIERTE} estado_t;
`else
  typedef enum logic [1:0] {VACIO, CARGANDO, LLENO, ENTREGA} estado_t;
`endif

  localparam logic [4:0] TECLA_LIMPIAR = 5'hE;
  localparam logic [4:0] TECLA_BORRAR  = 5'hF;
  localparam logic [4:0] SIN_TECLA     = 5'd16;
  localparam logic [4:0] SIN_COL       = 5'd17;

  function automatic logic es_letra(input logic [4:0] c);
    return (c >= 5'hA) && (c <= 5'hD);
  endfunction

  function automatic logic es_digito(input logic [4:0] c);
    return c <= 5'd9;
  endfunction

endpackage

// File: rtl/ingreso_numero_detector_flanco.sv
// Registered rising-edge detector; the history flop resets to RST_VAL so a
// level already high when reset is released produces no edge.
module detector_flanco #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_nivel,
  output logic o_flanco
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev   <= RST_VAL;
      o_flanco <= 1'b0;
    end else begin
      r_prev   <= i_nivel;
      o_flanco <= i_nivel & ~r_prev;
    end
  end

endmodule

// File: rtl/ingreso_numero.sv
// Calculator-style BCD digit entry with backspace/clear and a committed value on enter.
// Optional INGRESO_BIN_EN adds valor_bin via an iterative shift-add BCD-to-binary pass.
module ingreso_numero
  import ingreso_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int BIN_W    = 10,
  localparam int CW      = $clog2(N_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              digito,
  input  logic                    cambio_digito,
  input  logic                    enter_sync,
  output logic [4*N_DIGITS-1:0]   bcd_buf,
  output logic [CW-1:0]           cantidad,
  output logic [4*N_DIGITS-1:0]   valor,
  output logic                    valido,
  output logic                    error,
`ifdef INGRESO_BIN_EN
  output logic [BIN_W-1:0]        valor_bin,
`endif
  output logic                    desborde
);

  localparam logic [CW-1:0] CANT_MAX = CW'(N_DIGITS);

  logic                  w_ev_tecla, w_ev_enter, w_tecla_valida;
  logic [4:0]            r_codigo;
  estado_t               r_estado, w_estado_sig;
  logic [4*N_DIGITS-1:0] r_buf, w_buf, r_valor, w_valor;
  logic [CW-1:0]         r_cant, w_cant;
  logic                  r_valido, w_valido, r_error, w_error, r_desborde, w_desborde;

  detector_flanco #(.RST_VAL(1'b1)) u_flanco_tecla (
    .clk(clk), .rst(rst), .i_nivel(cambio_digito), .o_flanco(w_ev_tecla)
  );
  detector_flanco #(.RST_VAL(1'b1)) u_flanco_enter (
    .clk(clk), .rst(rst), .i_nivel(enter_sync), .o_flanco(w_ev_enter)
  );

  // Code is captured on the same edge as the key event so both line up one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_codigo <= SIN_TECLA;
    else     r_codigo <= digito;
  end

  assign w_tecla_valida = w_ev_tecla && (r_codigo != SIN_TECLA) && (r_codigo != SIN_COL);

`ifdef INGRESO_BIN_EN
  logic [4*N_DIGITS-1:0] r_snap, r_shift;
  logic [BIN_W-1:0]      r_acc, w_acc_sig, r_valor_bin;
  logic [CW-1:0]         r_idx;
  logic [3:0]            w_dig;

  assign w_dig     = r_shift[4*N_DIGITS-1 -: 4];
  assign w_acc_sig = (r_acc << 3) + (r_acc << 1) + BIN_W'(w_dig);
  assign valor_bin = r_valor_bin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap      <= '0;
      r_shift     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_valor_bin <= '0;
    end else if (r_estado == ENTREGA) begin
      r_snap  <= r_buf;
      r_shift <= r_buf;
      r_acc   <= '0;
      r_idx   <= '0;
    end else if (r_estado == CONVIERTE) begin
      r_shift <= r_shift << 4;
      r_acc   <= w_acc_sig;
      r_idx   <= r_idx + CW'(1);
      if (w_estado_sig == VACIO) r_valor_bin <= w_acc_sig;
    end
  end
`endif

  always_comb begin
    w_estado_sig = r_estado;
    w_buf        = r_buf;
    w_cant       = r_cant;
    w_valor      = r_valor;
    w_valido     = 1'b0;
    w_error      = 1'b0;
    w_desborde   = 1'b0;
    case (r_estado)
      ENTREGA: begin
        w_buf  = '0;
        w_cant = '0;
`ifdef INGRESO_BIN_EN
        w_estado_sig = CONVIERTE;
`else
        w_valor      = r_buf;
        w_valido     = 1'b1;
        w_estado_sig = VACIO;
`endif
      end
`ifdef INGRESO_BIN_EN
      CONVIERTE: begin
        if (r_idx == CW'(N_DIGITS - 1)) begin
          w_valor      = r_snap;
          w_valido     = 1'b1;
          w_estado_sig = VACIO;
        end
      end
`endif
      default: begin
        // Enter has priority over a simultaneous key event.
        if (w_ev_enter) begin
          if (r_estado == VACIO) w_error = 1'b1;
          else                   w_estado_sig = ENTREGA;
        end else if (w_tecla_valida) begin
          if (es_letra(r_codigo)) begin
            w_error = 1'b1;
          end else if (es_digito(r_codigo)) begin
            if (r_estado == LLENO) begin
              w_desborde = 1'b1;
            end else begin
              w_buf        = r_buf << 4;
              w_buf[3:0]   = r_codigo[3:0];
              w_cant       = r_cant + CW'(1);
              w_estado_sig = (w_cant == CANT_MAX) ? LLENO : CARGANDO;
            end
          end else if (r_codigo == TECLA_BORRAR) begin
            if (r_estado != VACIO) begin
              w_buf        = r_buf >> 4;
              w_cant       = r_cant - CW'(1);
              w_estado_sig = (r_cant == CW'(1)) ? VACIO : CARGANDO;
            end
          end else if (r_codigo == TECLA_LIMPIAR) begin
            w_buf        = '0;
            w_cant       = '0;
            w_estado_sig = VACIO;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado   <= VACIO;
      r_buf      <= '0;
      r_cant     <= '0;
      r_valor    <= '0;
      r_valido   <= 1'b0;
      r_error    <= 1'b0;
      r_desborde <= 1'b0;
    end else begin
      r_estado   <= w_estado_sig;
      r_buf      <= w_buf;
      r_cant     <= w_cant;
      r_valor    <= w_valor;
      r_valido   <= w_valido;
      r_error    <= w_error;
      r_desborde <= w_desborde;
    end
  end

  assign bcd_buf  = r_buf;
  assign cantidad = r_cant;
  assign valor    = r_valor;
  assign valido   = r_valido;
  assign error    = r_error;
  assign desborde = r_desborde;

endmodule

// File: tb/tb_ingreso_numero.sv
// Bench for ingreso_numero: integer-level reference model checked every cycle,
// plus directed key sequences with literal expectations. Honours INGRESO_BIN_EN.
module tb_ingreso_numero;

  localparam int N  = 3;
  localparam int CW = $clog2(N + 1);
  localparam int BW = 10;
`ifdef INGRESO_BIN_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    digito = 5'd16;
  logic          cambio_digito = 1'b0;
  logic          enter_sync = 1'b0;
  logic [4*N-1:0] bcd_buf, valor;
  logic [CW-1:0] cantidad;
  logic          valido, error, desborde;
`ifdef INGRESO_BIN_EN
  logic [BW-1:0] valor_bin;
`endif

  ingreso_numero #(.N_DIGITS(N), .BIN_W(BW)) dut (
    .clk(clk), .rst(rst), .digito(digito), .cambio_digito(cambio_digito),
    .enter_sync(enter_sync), .bcd_buf(bcd_buf), .cantidad(cantidad),
    .valor(valor), .valido(valido), .error(error),
`ifdef INGRESO_BIN_EN
    .valor_bin(valor_bin),
`endif
    .desborde(desborde)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model: the number is kept as a plain integer and digit count.
  int   m_num, m_cnt, m_snap, m_busy;
  bit   m_cleared, m_prev_c, m_prev_e, m_pk, m_pe;
  int   m_pc;
  int   e_valor_bin;
  logic [4*N-1:0] e_valor;
  bit   e_valido, e_error, e_desb;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_num = 0; m_cnt = 0; m_snap = 0; m_busy = 0; m_cleared = 1'b1;
        m_prev_c = 1'b1; m_prev_e = 1'b1; m_pk = 1'b0; m_pe = 1'b0; m_pc = 16;
        e_valor = '0; e_valor_bin = 0; e_valido = 1'b0; e_error = 1'b0; e_desb = 1'b0;
      end else begin
        e_valido = 1'b0; e_error = 1'b0; e_desb = 1'b0;
        if (m_busy > 0) begin
          if (!m_cleared) begin
            m_num = 0; m_cnt = 0; m_cleared = 1'b1;
          end
          m_busy--;
          if (m_busy == 0) begin
            e_valor = to_bcd(m_snap);
            e_valor_bin = m_snap;
            e_valido = 1'b1;
          end
        end else if (m_pe) begin
          if (m_cnt == 0) e_error = 1'b1;
          else begin
            m_snap = m_num; m_busy = LAT - 1; m_cleared = 1'b0;
          end
        end else if (m_pk) begin
          if (m_pc < 10) begin
            if (m_cnt == N) e_desb = 1'b1;
            else begin
              m_num = m_num * 10 + m_pc; m_cnt++;
            end
          end else if (m_pc >= 10 && m_pc <= 13) begin
            e_error = 1'b1;
          end else if (m_pc == 14) begin
            m_num = 0; m_cnt = 0;
          end else if (m_pc == 15) begin
            if (m_cnt > 0) begin
              m_num = m_num / 10; m_cnt--;
            end
          end
        end
        m_pk = cambio_digito && !m_prev_c;
        m_pe = enter_sync && !m_prev_e;
        m_pc = int'(digito);
        m_prev_c = cambio_digito;
        m_prev_e = enter_sync;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        chk("bcd_buf", bcd_buf, to_bcd(m_num));
        chk("cantidad", cantidad, m_cnt);
        chk("valor", valor, e_valor);
        chk("valido", valido, e_valido);
        chk("error", error, e_error);
        chk("desborde", desborde, e_desb);
`ifdef INGRESO_BIN_EN
        chk("valor_bin", valor_bin, e_valor_bin);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [4:0] c);
    step();
    digito = c;
    cambio_digito = 1'b1;
    step();
    cambio_digito = 1'b0;
    digito = 5'd16;
    step();
  endtask

  // Leaves the bench just after the edge on which valido must rise.
  task automatic do_enter();
    step();
    enter_sync = 1'b1;
    step();
    enter_sync = 1'b0;
    repeat (LAT - 1) step();
    chk("valido_early", valido, 1'b0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    digito = 5'd5;
    cambio_digito = 1'b1;
    enter_sync = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) step();
    chk("rst_bcd", bcd_buf, 12'h000);
    chk("rst_cant", cantidad, 0);
    chk("rst_valor", valor, 12'h000);
    chk("rst_valido", valido, 1'b0);
    chk("held_error", error, 1'b0);
    chk("rst_desborde", desborde, 1'b0);
    cambio_digito = 1'b0;
    enter_sync = 1'b0;
    digito = 5'd16;
    step();

    press(5'd1); chk("k1_bcd", bcd_buf, 12'h001); chk("k1_cant", cantidad, 1);
    press(5'd2); chk("k2_bcd", bcd_buf, 12'h012);
    press(5'd3); chk("k3_bcd", bcd_buf, 12'h123); chk("k3_cant", cantidad, 3);
    do_enter();
    chk("ent_valido", valido, 1'b1);
    chk("ent_valor", valor, 12'h123);
    chk("ent_bcd", bcd_buf, 12'h000);
    chk("ent_cant", cantidad, 0);
    step();
    chk("ent_pulse", valido, 1'b0);
    chk("ent_hold", valor, 12'h123);

    press(5'd4); press(5'd5); press(5'd6);
    press(5'd7);
    chk("ovf_pulse", desborde, 1'b1);
    chk("ovf_bcd", bcd_buf, 12'h456);
    step();
    chk("ovf_end", desborde, 1'b0);
    press(5'hF);
    chk("bs_bcd", bcd_buf, 12'h045);
    chk("bs_cant", cantidad, 2);
    press(5'hE);
    chk("clr_bcd", bcd_buf, 12'h000);

    step(); enter_sync = 1'b1;
    step(); enter_sync = 1'b0;
    step();
    chk("empty_err", error, 1'b1);
    chk("empty_valido", valido, 1'b0);

    press(5'd1);
    press(5'hB);
    chk("let_err", error, 1'b1);
    chk("let_bcd", bcd_buf, 12'h001);
    press(5'd2);
    chk("pre_bcd", bcd_buf, 12'h012);

    step();
    digito = 5'd9; cambio_digito = 1'b1; enter_sync = 1'b1;
    step();
    digito = 5'd16; cambio_digito = 1'b0; enter_sync = 1'b0;
    repeat (LAT) step();
    chk("sim_valido", valido, 1'b1);
    chk("sim_valor", valor, 12'h012);
    chk("sim_bcd", bcd_buf, 12'h000);

    press(5'd8); press(5'd2);
    chk("k82_bcd", bcd_buf, 12'h082);
    press(5'hE);
    chk("clr2_bcd", bcd_buf, 12'h000);
    chk("clr2_cant", cantidad, 0);
    press(5'd16);
    chk("nokey_cant", cantidad, 0);
    press(5'd0);
    chk("zero_cant", cantidad, 1);
    chk("zero_bcd", bcd_buf, 12'h000);
    press(5'hF); press(5'hF);
    chk("bs_empty", cantidad, 0);

    press(5'd9); press(5'd9); press(5'd9);
    do_enter();
    chk("n999_valor", valor, 12'h999);
    chk("n999_valido", valido, 1'b1);
`ifdef INGRESO_BIN_EN
    chk("n999_bin", valor_bin, 999);
`endif

    press(5'd5);
    step(); enter_sync = 1'b1;
    step(); enter_sync = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rstm_valido", valido, 1'b0);
    chk("rstm_valor", valor, 12'h000);
    chk("rstm_bcd", bcd_buf, 12'h000);
    chk("rstm_cant", cantidad, 0);
    rst = 1'b0;
    repeat (LAT + 2) step();
    chk("rstm_cut", valido, 1'b0);
    chk("rstm_valor2", valor, 12'h000);

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
